// File: rtl/shiftreg_deser.sv
`default_nettype none
// ============================================================================
// Module   : shiftreg_deser
// Purpose  : Serial-to-parallel collector for the modular-multiplication
//            datapath. It captures one bit per enabled clock, LSB first, and
//            assembles a WIDTH-bit word. The completed word is offered to the
//            control FSM with a valid/ack handshake. The module also counts
//            bits, detects completion and flags overrun.
// Ports    : clk        - system clock, rising edge
//            rst        - synchronous reset, active-high
//            clr        - synchronous clear (per-multiplication restart)
//            start      - begin a new capture
//            en         - bit strobe; bit_i sampled only when en=1
//            bit_i      - serial data, LSB first
//            ack_i      - consumer accepts word_o
//            word_o     - assembled word, stable while word_vld_o=1
//            word_vld_o - word_o valid, held until ack_i
//            busy_o     - capture in progress
//            ovf_o      - sticky: bit arrived while a word was unacknowledged
//            cnt_o      - bits captured in the current word
// Revision : 1.0 - initial release
// ============================================================================
module shiftreg_deser #(
  parameter  int WIDTH = 10,
  localparam int CNTW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             start,
  input  logic             en,
  input  logic             bit_i,
  input  logic             ack_i,
  output logic [WIDTH-1:0] word_o,
  output logic             word_vld_o,
  output logic             busy_o,
  output logic             ovf_o,
  output logic [CNTW-1:0]  cnt_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam logic [CNTW-1:0] LAST_BIT = CNTW'(WIDTH - 1);

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  shreg_q, shreg_d;
  logic [WIDTH-1:0]  word_q,  word_d;
  logic [CNTW-1:0]   cnt_q,   cnt_d;
  logic              ovf_q,   ovf_d;
  logic [WIDTH-1:0]  shifted;

  // New bit enters at the MSB; after WIDTH strobes the first (LSB) bit
  // has walked down to bit 0.
  assign shifted = {bit_i, shreg_q[WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    word_d  = word_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;

    if (clr) begin
      state_d = IDLE;
      shreg_d = '0;
      word_d  = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_d = SHIFT;
            shreg_d = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
          end
        end

        SHIFT: begin
          if (start) begin
            // Restart wins over the strobe; the bit on bit_i is discarded.
            shreg_d = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
          end else if (en) begin
            shreg_d = shifted;
            if (cnt_q == LAST_BIT) begin
              word_d  = shifted;
              cnt_d   = '0;
              state_d = FULL;
            end else begin
              cnt_d = cnt_q + CNTW'(1);
            end
          end
        end

        FULL: begin
          if (ack_i && start) begin
            // Back-to-back word: skip IDLE entirely.
            state_d = SHIFT;
            shreg_d = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
          end else begin
            if (en)    ovf_d   = 1'b1;
            if (ack_i) state_d = IDLE;
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      word_q  <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign word_o     = word_q;
  assign word_vld_o = (state_q == FULL);
  assign busy_o     = (state_q == SHIFT);
  assign ovf_o      = ovf_q;
  assign cnt_o      = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_shiftreg_deser.sv
`default_nettype none
// ============================================================================
// Module   : tb_shiftreg_deser
// Purpose  : Directed self-checking bench for shiftreg_deser (WIDTH=10).
//            Inputs change on the falling edge; outputs are checked 1 ns
//            after the rising edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shiftreg_deser;

  localparam int WIDTH = 10;
  localparam int CNTW  = $clog2(WIDTH);

  logic             clk = 1'b0;
  logic             rst, clr, start, en, bit_i, ack_i;
  logic [WIDTH-1:0] word_o;
  logic             word_vld_o, busy_o, ovf_o;
  logic [CNTW-1:0]  cnt_o;

  int n_cmp = 0;
  int n_bad = 0;

  shiftreg_deser #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .start      (start),
    .en         (en),
    .bit_i      (bit_i),
    .ack_i      (ack_i),
    .word_o     (word_o),
    .word_vld_o (word_vld_o),
    .busy_o     (busy_o),
    .ovf_o      (ovf_o),
    .cnt_o      (cnt_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive all inputs at negedge, return 1 ns after the rising edge.
  task automatic step(input logic r, input logic c, input logic s,
                      input logic e, input logic b, input logic a);
    @(negedge clk);
    rst = r; clr = c; start = s; en = e; bit_i = b; ack_i = a;
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic b);
    step(1'b0, 1'b0, 1'b0, 1'b1, b, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_start();
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_ack();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic send_word(input logic [WIDTH-1:0] w);
    for (int i = 0; i < WIDTH; i++) strobe(w[i]);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_word"}, 32'(word_o), 32'h0);
    check({tag, "_vld"},  32'(word_vld_o), 32'h0);
    check({tag, "_busy"}, 32'(busy_o), 32'h0);
    check({tag, "_ovf"},  32'(ovf_o), 32'h0);
    check({tag, "_cnt"},  32'(cnt_o), 32'h0);
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; start = 1'b0; en = 1'b0; bit_i = 1'b0; ack_i = 1'b0;

    // ---- 1: reset, basic word 0x2B5 --------------------------------------
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_zero("t1_rst");
    do_start();
    check("t1_busy_start", 32'(busy_o), 32'h1);
    check("t1_cnt_start",  32'(cnt_o),  32'h0);
    for (int i = 0; i < WIDTH - 1; i++) strobe(WIDTH'(10'h2B5) >> i);
    check("t1_cnt9", 32'(cnt_o), 32'd9);
    check("t1_vld9", 32'(word_vld_o), 32'h0);
    strobe(1'b1);                       // bit 9 of 0x2B5
    check("t1_vld",  32'(word_vld_o), 32'h1);
    check("t1_word", 32'(word_o), 32'h2B5);
    check("t1_busy", 32'(busy_o), 32'h0);
    check("t1_cnt",  32'(cnt_o),  32'h0);
    do_ack();
    check("t1_vld_ack",  32'(word_vld_o), 32'h0);
    check("t1_busy_ack", 32'(busy_o), 32'h0);
    do_ack();                           // ack outside FULL has no effect
    check("t1_vld_idle_ack", 32'(word_vld_o), 32'h0);

    // ---- 2: en gap between bits 4 and 5 ----------------------------------
    do_start();
    for (int i = 0; i < 5; i++) strobe(WIDTH'(10'h2B5) >> i);
    check("t2_cnt_pre", 32'(cnt_o), 32'd5);
    for (int g = 0; g < 3; g++) begin
      idle();
      check("t2_cnt_gap", 32'(cnt_o), 32'd5);
    end
    for (int i = 5; i < WIDTH; i++) strobe(WIDTH'(10'h2B5) >> i);
    check("t2_vld",  32'(word_vld_o), 32'h1);
    check("t2_word", 32'(word_o), 32'h2B5);
    do_ack();

    // ---- 3: overrun while FULL ------------------------------------------
    do_start();
    send_word(10'h3FF);
    check("t3_vld", 32'(word_vld_o), 32'h1);
    check("t3_ovf0", 32'(ovf_o), 32'h0);
    strobe(1'b0);
    strobe(1'b0);
    check("t3_word_frozen", 32'(word_o), 32'h3FF);
    check("t3_ovf", 32'(ovf_o), 32'h1);
    do_start();                         // start without ack is ignored
    check("t3_vld_start", 32'(word_vld_o), 32'h1);
    check("t3_busy_start", 32'(busy_o), 32'h0);
    check("t3_ovf_start", 32'(ovf_o), 32'h1);
    do_ack();
    check("t3_vld_ack", 32'(word_vld_o), 32'h0);
    check("t3_ovf_ack", 32'(ovf_o), 32'h1);
    do_start();
    check("t3_ovf_clr", 32'(ovf_o), 32'h0);
    check("t3_busy", 32'(busy_o), 32'h1);

    // ---- 4: ack + start back-to-back ------------------------------------
    send_word(10'h2B5);
    check("t4_vld1", 32'(word_vld_o), 32'h1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    check("t4_busy_b2b", 32'(busy_o), 32'h1);
    check("t4_vld_b2b",  32'(word_vld_o), 32'h0);
    check("t4_cnt_b2b",  32'(cnt_o), 32'h0);
    for (int i = 0; i < WIDTH - 1; i++) strobe(WIDTH'(10'h155) >> i);
    check("t4_vld9", 32'(word_vld_o), 32'h0);
    strobe(1'b0);                       // bit 9 of 0x155
    check("t4_vld",  32'(word_vld_o), 32'h1);
    check("t4_word", 32'(word_o), 32'h155);
    do_ack();

    // ---- 5: clr mid-capture ---------------------------------------------
    do_start();
    for (int i = 0; i < 6; i++) strobe(1'b1);
    check("t5_cnt6", 32'(cnt_o), 32'd6);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("t5_vld",  32'(word_vld_o), 32'h0);
    check("t5_cnt",  32'(cnt_o), 32'h0);
    check("t5_busy", 32'(busy_o), 32'h0);
    do_start();
    send_word(10'h001);
    check("t5_vld2", 32'(word_vld_o), 32'h1);
    check("t5_word", 32'(word_o), 32'h001);
    do_ack();

    // ---- 6: reset in FULL, en in IDLE ignored ---------------------------
    do_start();
    send_word(10'h2B5);
    check("t6_word", 32'(word_o), 32'h2B5);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_zero("t6_rst");
    for (int i = 0; i < 3; i++) strobe(1'b1);
    check("t6_cnt_idle", 32'(cnt_o), 32'h0);
    check("t6_ovf_idle", 32'(ovf_o), 32'h0);
    check("t6_busy_idle", 32'(busy_o), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/shiftreg_deser.md
Name: shiftreg_deser

Overview:
Serial-to-parallel collector for the modular-multiplication datapath. It is the receiving end of the operand serializer: it captures one bit per enabled clock, LSB first, and assembles a WIDTH-bit result word. Once the word is complete, it presents the word with a valid/ack handshake to the control FSM. It also counts bits, detects completion and flags overrun, so the control logic never tracks bit position itself.

Parameters:
WIDTH, 10, word length in bits (≥2); matches the operand width of the serializer.
CNTW, $clog2(WIDTH), width of the internal bit counter (derived; not overridden).

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
clr  input  1  synchronous clear of a capture in progress (per-multiplication restart)
start  input  1  begin a new capture; clears counter and shift register
en  input  1  bit strobe; bit_i is sampled only when en=1
bit_i  input  1  serial data, LSB first
ack_i  input  1  consumer accepts word_o
word_o  output  WIDTH  assembled word, held stable while word_vld_o=1
word_vld_o  output  1  level: word_o is valid, held until ack_i
busy_o  output  1  capture in progress (state SHIFT)
ovf_o  output  1  sticky: a bit arrived while a completed word was still unacknowledged
cnt_o  output  CNTW  number of bits captured in the current word

Behaviour:
- Reset (rst=1 at clk edge) → state IDLE; shreg=0, cnt_o=0, word_o=0, word_vld_o=0, busy_o=0, ovf_o=0.
- Priority each edge: rst > clr > start > en/ack.
- clr=1 in any state → same clear as rst. A clr during SHIFT discards the partial word.
- States:
  - IDLE: en is ignored, and no bits or overrun are recorded. start → SHIFT with shreg=0, cnt=0, ovf cleared.
  - SHIFT (busy_o=1): on en, shreg ← {bit_i, shreg[WIDTH-1:1]} (shift right, new bit enters at MSB), and cnt increments.
    - When en=1 and cnt=WIDTH-1: word_o ← {bit_i, shreg[WIDTH-1:1]}, word_vld_o ← 1, cnt ← 0, next state FULL.
    - start during SHIFT → restart: shreg=0, cnt=0; the bit presented that cycle is discarded.
  - FULL (word_vld_o=1): word_o is frozen.
    - en=1 → bit dropped, ovf_o ← 1 (sticky).
    - ack_i=1 → word_vld_o ← 0, next state IDLE.
    - ack_i=1 and start=1 in the same cycle → next state SHIFT directly (back-to-back words, no idle cycle).
    - start without ack → ignored.
- Latency: word_vld_o rises on the edge that samples bit WIDTH-1, so it is visible the cycle after the last en. Minimum period between words is WIDTH+1 cycles (WIDTH strobes + 1 ack/start cycle).
- ovf_o is cleared only by rst, clr or an accepted start.
- ack_i outside FULL has no effect.
- The en gap between bits is arbitrary; cnt holds while en=0.
- cnt_o counts 0..WIDTH-1 and never reaches WIDTH; it returns to 0 when the word completes.

Test Plan:
1. rst, then start, then 10 en strobes carrying 0x2B5 LSB first (1,0,1,0,1,1,0,1,0,1) → word_o=0x2B5, word_vld_o=1 one cycle after the 10th strobe; busy_o=0; after ack_i, word_vld_o=0 and state is IDLE.
2. Same word with en deasserted for 3 cycles between bits 4 and 5 → cnt_o holds at 5 during the gap; final word_o=0x2B5.
3. FULL holding 0x3FF, two en strobes before ack → word_o stays 0x3FF, ovf_o=1; ovf_o stays set after ack; next start clears it.
4. ack_i and start in the same cycle, then 10 strobes of 0x155 → no IDLE cycle; second word_o=0x155, valid WIDTH cycles after the restart.
5. clr asserted after 6 bits → word_vld_o=0, cnt_o=0, busy_o=0; a subsequent start + 10 bits of 0x001 yields 0x001.
6. rst asserted in FULL with word_o=0x2B5 → all outputs 0 on the next cycle; en strobes in IDLE leave cnt_o=0 and ovf_o=0.
